// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for the EX stage: DIV/DIVU/REM/REMU, result = {rem, quot}.
// Latency 33 edges from accept (2 for divide-by-zero); start_i held high until ready_o, dropping it aborts/acks.
module ex_div #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ZERO = 2'd1,
        S_ON   = 2'd2,
        S_END  = 2'd3
    } state_t;

    state_t              r_state;
    logic [5:0]          r_cnt;
    logic [2*DATA_W:0]   r_work;
    logic [DATA_W-1:0]   r_dvsr;
    logic                r_sign_q;
    logic                r_sign_r;

    logic                w_neg1;
    logic                w_neg2;
    logic [DATA_W-1:0]   w_abs1;
    logic [DATA_W-1:0]   w_abs2;
    logic [DATA_W:0]     w_diff;
    logic [2*DATA_W:0]   w_step;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_quot_fix;
    logic [DATA_W-1:0]   w_rem_fix;
    logic [2*DATA_W:0]   w_final;

    always_comb begin
        w_neg1     = signed_div_i & opdata1_i[DATA_W-1];
        w_neg2     = signed_div_i & opdata2_i[DATA_W-1];
        w_abs1     = w_neg1 ? -opdata1_i : opdata1_i;
        w_abs2     = w_neg2 ? -opdata2_i : opdata2_i;
        // Trial subtraction on the upper half; a borrow means the divisor did not fit.
        w_diff     = r_work[2*DATA_W:DATA_W] - {1'b0, r_dvsr};
        w_step     = w_diff[DATA_W] ? {r_work[2*DATA_W-1:0], 1'b0}
                                    : {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
        w_quot     = w_step[DATA_W-1:0];
        w_rem      = w_step[2*DATA_W:DATA_W+1];
        w_quot_fix = r_sign_q ? -w_quot : w_quot;
        w_rem_fix  = r_sign_r ? -w_rem : w_rem;
        w_final    = {w_rem_fix, w_step[DATA_W], w_quot_fix};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_work   <= '0;
            r_dvsr   <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else if (annul_i) begin
            r_state  <= S_IDLE;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ready_o <= 1'b0;
                    if (start_i) begin
                        r_cnt <= '0;
                        if (opdata2_i == '0) begin
                            // Pre-load the RISC-V divide-by-zero answer; END publishes it.
                            r_work   <= {opdata1_i, 1'b0, {DATA_W{1'b1}}};
                            r_sign_q <= 1'b0;
                            r_sign_r <= 1'b0;
                            r_state  <= S_ZERO;
                        end else begin
                            r_work   <= {{DATA_W{1'b0}}, w_abs1, 1'b0};
                            r_dvsr   <= w_abs2;
                            r_sign_q <= w_neg1 ^ w_neg2;
                            r_sign_r <= w_neg1;
                            r_state  <= S_ON;
                        end
                    end
                end
                S_ZERO: begin
                    r_state <= S_END;
                end
                S_ON: begin
                    if (!start_i) begin
                        r_state  <= S_IDLE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'(DATA_W - 1)) begin
                            r_work  <= w_final;
                            r_state <= S_END;
                        end else begin
                            r_work <= w_step;
                        end
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        r_state  <= S_IDLE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        result_o <= {r_work[2*DATA_W:DATA_W+1], r_work[DATA_W-1:0]};
                        ready_o  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative 32-bit radix-2 divider instantiated inside the EX stage.
- Consumes the operands the ID/EX register delivers for DIV/DIVU/REM/REMU.
- While a division is in flight, EX holds its stall request (into the stall[5:0] controller) until ready_o.
- Returns quotient and remainder together; EX selects the word for ex_wd.

Parameters:
- DATA_W, 32, operand width; the 6-bit counter and 65-bit work register are sized for 32.

Ports:
- clk  input  1  pipeline clock, all state updates on posedge.
- rst  input  1  synchronous active-high reset (rst == `RstEnable, 1'b1), sampled on posedge clk.
- signed_div_i  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with start_i.
- opdata1_i  input  32  dividend; sampled with start_i.
- opdata2_i  input  32  divisor; sampled with start_i.
- start_i  input  1  request; EX holds it high until it sees ready_o.
- annul_i  input  1  abort (pipeline flush); highest priority after rst.
- result_o  output  64  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  output  1  result_o valid; registered.

Behaviour:
- Clocking and reset:
  - All logic is synchronous to posedge clk.
  - rst=1 at an edge: state=IDLE, cnt=0, work register=0, sign flags=0, result_o=0, ready_o=0.
  - Reset is honoured in every state, so it aborts an operation mid-flight with no residual state.
- States: IDLE, ZERO, ON, END (2-bit encoding).
- Priority at each edge: rst > annul_i > state logic.
  - annul_i=1 in any state: go to IDLE, ready_o=0, result_o=0.
- IDLE:
  - start_i=1, annul_i=0, opdata2_i==0: go to ZERO.
  - start_i=1, annul_i=0, opdata2_i!=0: go to ON, cnt=0.
  - On either start path, latch the operands. In signed mode the magnitudes are latched, along with sign_q = op1[31]^op2[31] and sign_r = op1[31].
  - ready_o=0 throughout IDLE.
- ZERO:
  - Next edge: go to END.
  - Result follows RISC-V rules in both modes: quotient=32'hFFFFFFFF, remainder=original opdata1 (unsigned bit pattern, no sign correction).
- ON: one restoring step per edge on the 65-bit work register W.
  - Initialisation: W = {32'b0, |dividend|, 1'b0}.
  - Step: diff = W[64:32] - {1'b0,|divisor|}.
    - diff negative: W = W << 1.
    - Otherwise: W = {diff[31:0], W[31:0], 1'b1}.
  - cnt increments on every step.
  - start_i dropping to 0 while in ON is treated as annul.
- Completion, on the step with cnt==31:
  - Go to END, ready_o=1.
  - Unsigned mode: quotient = W[31:0] after the final step, remainder = W[64:33] after the final step.
  - Signed mode: negate the quotient if sign_q=1 and negate the remainder if sign_r=1 (two's complement, 32-bit wrap).
  - Overflow falls out with no special case: -2^31 / -1 gives quotient 32'h80000000, remainder 0.
- END:
  - ready_o=1; result_o is held stable.
  - Stay in END while start_i=1.
  - start_i=0: go to IDLE; ready_o=0 and result_o=0 on that same edge.
  - A new start therefore needs at least one cycle of start_i=0.
- Latency, where E0 is the edge that accepts start:
  - Normal case: ready_o=1 after edge E33, i.e. 33 cycles of stall.
  - Divide-by-zero: ready_o=1 after edge E2.
- Inputs are not re-sampled after E0, so changes on opdata*_i mid-operation have no effect.

Test Plan:
- Unsigned: start, signed=0, 100/7 → ready_o high exactly 33 edges after acceptance; result_o = {32'd2, 32'd14}. Also 32'hFFFFFFFF/1 → {0, 32'hFFFFFFFF}.
- Signed sign matrix:
  - -7/2 → {32'hFFFFFFFF, 32'hFFFFFFFD}
  - 7/-2 → {32'd1, 32'hFFFFFFFD}
  - -7/-2 → {32'hFFFFFFFF, 32'd3}
- Divide-by-zero: signed=1, opdata1=32'hFFFFFFF6 (-10), opdata2=0 → ready_o after 2 edges; result_o = {32'hFFFFFFF6, 32'hFFFFFFFF}. Same check for unsigned.
- Overflow: signed, 32'h80000000 / 32'hFFFFFFFF → {32'h0, 32'h80000000} after 33 edges.
- Abort:
  - annul_i pulse at cnt=10 → IDLE next edge, ready_o=0, result_o=0. A restart with 9/3 then completes correctly: {0, 3}.
  - Repeat the test using rst=1 instead of annul_i, with the same required response.
- Handshake: hold start_i high 5 cycles after ready_o → result_o stable, state END. Drop start_i → ready_o=0 next edge. A back-to-back start after one idle cycle is accepted.
